// File: rtl/decode_writeback.sv
// SEQ Y86-64 decode/write-back: register ID selection, combinational register reads,
// and end-of-cycle commit of valE/valM into the 15-entry program register file.
module decode_writeback #(
  parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_0200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        wb_en,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  input  logic [3:0]  dbg_addr,
  output logic [63:0] dbg_data
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  logic [63:0] regs [15];

  function automatic logic [63:0] rd_reg(input logic [3:0] id, input logic [63:0] q [15]);
    rd_reg = (id == RNONE) ? 64'h0 : q[id];
  endfunction

  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (icode)
      4'h2: begin
        srcA = rA;
        dstE = cnd ? rB : RNONE;
      end
      4'h3: dstE = rB;
      4'h4: begin
        srcA = rA;
        srcB = rB;
      end
      4'h5: begin
        srcB = rB;
        dstM = rA;
      end
      4'h6: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      4'h8: begin
        srcB = RRSP;
        dstE = RRSP;
      end
      4'h9: begin
        srcA = RRSP;
        srcB = RRSP;
        dstE = RRSP;
      end
      4'hA: begin
        srcA = rA;
        srcB = RRSP;
        dstE = RRSP;
      end
      4'hB: begin
        srcA = RRSP;
        srcB = RRSP;
        dstE = RRSP;
        dstM = rA;
      end
      default: ;
    endcase
  end

  // Reads see only committed contents; no bypass from the write port.
  assign valA     = rd_reg(srcA, regs);
  assign valB     = rd_reg(srcB, regs);
  assign dbg_data = rd_reg(dbg_addr, regs);

  // dstM is assigned last so a load into the same register (popq %rsp) wins over valE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) regs[i] <= (i == 4) ? STACK_INIT : 64'h0;
    end else if (wb_en) begin
      if (dstE != RNONE) regs[dstE] <= valE;
      if (dstM != RNONE) regs[dstM] <= valM;
    end
  end

endmodule

// File: tb/tb_decode_writeback.sv
// Directed bench for decode_writeback: decode IDs, reads, write-back ordering and reset.
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  icode, rA, rB;
  logic        cnd, wb_en;
  logic [63:0] valE, valM;
  logic [63:0] valA, valB, dbg_data;
  logic [3:0]  srcA, srcB, dstE, dstM, dbg_addr;

  int checks = 0;
  int errors = 0;

  decode_writeback dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
    .valE(valE), .valM(valM), .wb_en(wb_en), .valA(valA), .valB(valB),
    .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [63:0] e, input logic [63:0] m, input logic w);
    icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m; wb_en = w;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (dbg_data !== 64'h0) begin errors++; $display("FAIL rst_r0 got %h want %h", dbg_data, 64'h0); end
    dbg_addr = 4'd4; #1;
    checks++; if (dbg_data !== 64'h200) begin errors++; $display("FAIL rst_rsp got %h want %h", dbg_data, 64'h200); end
    rst_n = 1'b1;
    drive(4'h3, 4'hF, 4'h0, 1'b0, 64'h55, 64'h0, 1'b1);
    step();
    dbg_addr = 4'd0; #1;
    checks++; if (dbg_data !== 64'h55) begin errors++; $display("FAIL rax_written got %h want %h", dbg_data, 64'h55); end
    drive(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
    #1 rst_n = 1'b0; #1;
    checks++; if (dbg_data !== 64'h0) begin errors++; $display("FAIL async_rst_rax got %h want %h", dbg_data, 64'h0); end
    dbg_addr = 4'd4; #1;
    checks++; if (dbg_data !== 64'h200) begin errors++; $display("FAIL async_rst_rsp got %h want %h", dbg_data, 64'h200); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_irmovq();
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'hDEAD_BEEF, 64'h0, 1'b1);
    checks++; if (dstE !== 4'h2 || dstM !== 4'hF) begin errors++; $display("FAIL irmovq_ids got %h/%h want 2/f", dstE, dstM); end
    step();
    dbg_addr = 4'd2; #1;
    checks++; if (dbg_data !== 64'hDEAD_BEEF) begin errors++; $display("FAIL irmovq_r2 got %h want %h", dbg_data, 64'hDEAD_BEEF); end
    drive(4'h6, 4'h2, 4'h2, 1'b0, 64'h0, 64'h0, 1'b0);
    checks++; if (valA !== 64'hDEAD_BEEF || valB !== 64'hDEAD_BEEF) begin errors++; $display("FAIL opq_reads got %h/%h want deadbeef", valA, valB); end
  endtask

  task automatic test_push_pop();
    drive(4'hA, 4'h3, 4'hF, 1'b0, 64'h1F8, 64'h0, 1'b1);
    checks++; if (srcA !== 4'h3 || srcB !== 4'h4 || dstE !== 4'h4 || dstM !== 4'hF) begin
      errors++; $display("FAIL push_ids got %h %h %h %h want 3 4 4 f", srcA, srcB, dstE, dstM); end
    checks++; if (valB !== 64'h200) begin errors++; $display("FAIL push_valB got %h want %h", valB, 64'h200); end
    step();
    dbg_addr = 4'd4; #1;
    checks++; if (dbg_data !== 64'h1F8) begin errors++; $display("FAIL push_rsp got %h want %h", dbg_data, 64'h1F8); end
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h200, 64'h77, 1'b1);
    checks++; if (dstE !== 4'h4 || dstM !== 4'h4 || srcA !== 4'h4) begin errors++; $display("FAIL pop_ids got %h %h %h want 4 4 4", dstE, dstM, srcA); end
    step();
    checks++; if (dbg_data !== 64'h77) begin errors++; $display("FAIL pop_rsp got %h want %h", dbg_data, 64'h77); end
  endtask

  task automatic test_cmov();
    dbg_addr = 4'd5;
    drive(4'h2, 4'h1, 4'h5, 1'b0, 64'h9, 64'h0, 1'b1);
    checks++; if (dstE !== 4'hF || srcA !== 4'h1 || srcB !== 4'hF) begin errors++; $display("FAIL cmov0_ids got %h %h %h want f 1 f", dstE, srcA, srcB); end
    step();
    checks++; if (dbg_data !== 64'h0) begin errors++; $display("FAIL cmov0_rbp got %h want %h", dbg_data, 64'h0); end
    drive(4'h2, 4'h1, 4'h5, 1'b1, 64'h9, 64'h0, 1'b1);
    checks++; if (dstE !== 4'h5) begin errors++; $display("FAIL cmov1_dstE got %h want 5", dstE); end
    step();
    checks++; if (dbg_data !== 64'h9) begin errors++; $display("FAIL cmov1_rbp got %h want %h", dbg_data, 64'h9); end
  endtask

  task automatic test_suppress();
    dbg_addr = 4'd6;
    drive(4'h3, 4'hF, 4'h6, 1'b0, 64'h1, 64'h0, 1'b0);
    step();
    checks++; if (dbg_data !== 64'h0) begin errors++; $display("FAIL wb_off_rsi got %h want %h", dbg_data, 64'h0); end
    drive(4'hC, 4'h2, 4'h2, 1'b1, 64'h3, 64'h4, 1'b1);
    checks++; if (srcA !== 4'hF || srcB !== 4'hF || dstE !== 4'hF || dstM !== 4'hF) begin
      errors++; $display("FAIL icC_ids got %h %h %h %h want f f f f", srcA, srcB, dstE, dstM); end
    checks++; if (valA !== 64'h0 || valB !== 64'h0) begin errors++; $display("FAIL icC_reads got %h/%h want 0/0", valA, valB); end
    drive(4'h5, 4'h8, 4'h2, 1'b0, 64'h0, 64'hABC, 1'b1);
    checks++; if (dstM !== 4'h8 || dstE !== 4'hF || srcB !== 4'h2) begin errors++; $display("FAIL mrmov_ids got %h %h %h want 8 f 2", dstM, dstE, srcB); end
    step();
    dbg_addr = 4'd8; #1;
    checks++; if (dbg_data !== 64'hABC) begin errors++; $display("FAIL mrmov_r8 got %h want %h", dbg_data, 64'hABC); end
  endtask

  task automatic test_read_during_write();
    drive(4'h3, 4'hF, 4'h7, 1'b0, 64'h5, 64'h0, 1'b1);
    step();
    drive(4'h6, 4'h7, 4'h7, 1'b0, 64'hA, 64'h0, 1'b1);
    checks++; if (valA !== 64'h5 || valB !== 64'h5) begin errors++; $display("FAIL rdw_before got %h/%h want 5/5", valA, valB); end
    step();
    checks++; if (valA !== 64'hA) begin errors++; $display("FAIL rdw_after got %h want %h", valA, 64'hA); end
  endtask

  task automatic test_reset_wins();
    dbg_addr = 4'd0;
    drive(4'h3, 4'hF, 4'h0, 1'b0, 64'h99, 64'h0, 1'b1);
    rst_n = 1'b0;
    step();
    checks++; if (dbg_data !== 64'h0) begin errors++; $display("FAIL rst_wins_rax got %h want %h", dbg_data, 64'h0); end
    dbg_addr = 4'd7; #1;
    checks++; if (dbg_data !== 64'h0) begin errors++; $display("FAIL rst_wins_r7 got %h want %h", dbg_data, 64'h0); end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; dbg_addr = 4'd0;
    drive(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
    step();
    test_reset();
    test_irmovq();
    test_push_pop();
    test_cmov();
    test_suppress();
    test_read_during_write();
    test_reset_wins();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
